// File: rtl/alu_sequencer.sv
// ============================================================================
// Module   : alu_sequencer
// Brief    : Fetch/decode sequencer driving the accumulator ALU command inputs
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            Clk,
    input  logic            RST,
    input  logic            start,
    output logic            ins_req,
    output logic [PC_W-1:0] ins_addr,
    input  logic            ins_valid,
    input  logic [15:0]     ins_data,
    input  logic [7:0]      alu_dout,
    output logic [7:0]      bus_out,
    output logic            alu_wen,
    output logic            alu_inc,
    output logic            alu_clr,
    output logic [2:0]      alu_op,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_SETTLE = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] c_OP_NOP  = 4'd0;
    localparam logic [3:0] c_OP_LDI  = 4'd1;
    localparam logic [3:0] c_OP_ALU  = 4'd2;
    localparam logic [3:0] c_OP_INC  = 4'd3;
    localparam logic [3:0] c_OP_CLR  = 4'd4;
    localparam logic [3:0] c_OP_JMP  = 4'd5;
    localparam logic [3:0] c_OP_JZ   = 4'd6;
    localparam logic [3:0] c_OP_HALT = 4'd7;

    state_t            r_state;
    state_t            w_state_next;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_next;
    // Only the decoded fields are kept; instruction bit 11 has no meaning.
    logic [3:0]        r_opcode;
    logic [2:0]        r_op_field;
    logic [7:0]        r_imm;
    logic [PC_W-1:0]   w_imm_pc;

    assign w_imm_pc = PC_W'(r_imm);

    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_opcode   <= '0;
            r_op_field <= '0;
            r_imm      <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (r_state == S_FETCH && ins_valid) begin
                r_opcode   <= ins_data[15:12];
                r_op_field <= ins_data[10:8];
                r_imm      <= ins_data[7:0];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        ins_req      = 1'b0;
        bus_out      = 8'h00;
        alu_wen      = 1'b0;
        alu_inc      = 1'b0;
        alu_clr      = 1'b0;
        alu_op       = 3'b000;
        illegal      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_FETCH;
                    w_pc_next    = '0;
                end
            end
            S_FETCH: begin
                ins_req = 1'b1;
                if (ins_valid) begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_next = S_SETTLE;
                w_pc_next    = r_pc + 1'b1;
                case (r_opcode)
                    c_OP_NOP: ;
                    c_OP_LDI: begin
                        bus_out = r_imm;
                        alu_wen = 1'b1;
                    end
                    c_OP_ALU: begin
                        bus_out = r_imm;
                        alu_op  = r_op_field;
                        alu_wen = 1'b1;
                    end
                    c_OP_INC: alu_inc = 1'b1;
                    c_OP_CLR: alu_clr = 1'b1;
                    c_OP_JMP: w_pc_next = w_imm_pc;
                    c_OP_JZ: begin
                        if (alu_dout == 8'h00) begin
                            w_pc_next = w_imm_pc;
                        end
                    end
                    c_OP_HALT: begin
                        w_state_next = S_HALT;
                        w_pc_next    = r_pc;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            S_SETTLE: w_state_next = S_FETCH;
            S_HALT:   w_state_next = S_HALT;
            default:  w_state_next = S_IDLE;
        endcase
    end

    assign ins_addr = r_pc;
    assign busy     = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted   = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Directed self-checking bench for alu_sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

    logic        Clk = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        ins_req;
    logic [7:0]  ins_addr;
    logic        ins_valid;
    logic [15:0] ins_data;
    logic [7:0]  alu_dout = 8'h00;
    logic [7:0]  bus_out;
    logic        alu_wen;
    logic        alu_inc;
    logic        alu_clr;
    logic [2:0]  alu_op;
    logic        busy;
    logic        halted;
    logic        illegal;

    logic [15:0] rom [256];
    logic        force_valid = 1'b0;
    int          wait_cycles = 0;
    int          req_cnt = 0;
    int          total = 0;
    int          bad = 0;

    always #5 Clk = ~Clk;

    alu_sequencer #(.PC_W(8)) dut (
        .Clk       (Clk),
        .RST       (RST),
        .start     (start),
        .ins_req   (ins_req),
        .ins_addr  (ins_addr),
        .ins_valid (ins_valid),
        .ins_data  (ins_data),
        .alu_dout  (alu_dout),
        .bus_out   (bus_out),
        .alu_wen   (alu_wen),
        .alu_inc   (alu_inc),
        .alu_clr   (alu_clr),
        .alu_op    (alu_op),
        .busy      (busy),
        .halted    (halted),
        .illegal   (illegal)
    );

    // ROM model: answers after wait_cycles cycles of continuous request
    always @(posedge Clk) begin
        if (!ins_req) req_cnt <= 0;
        else          req_cnt <= req_cnt + 1;
    end
    assign ins_valid = force_valid | (ins_req && (req_cnt >= wait_cycles));
    assign ins_data  = rom[ins_addr];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;

        // Reset with ins_valid forced high
        force_valid = 1'b1;
        RST = 1'b1;
        tick();
        tick();
        chk("rst_outputs", {ins_req, ins_addr, bus_out, alu_op, alu_wen, alu_inc,
                            alu_clr, busy, halted, illegal}, 32'h0);
        RST = 1'b0;
        tick();
        tick();
        chk("idle_no_req", {ins_req, busy, halted, ins_addr}, 32'h0);
        force_valid = 1'b0;

        // Straight-line LDI 0x14; INC; HALT with start held high throughout
        rom[0] = 16'h1014;
        rom[1] = 16'h3000;
        rom[2] = 16'h7000;
        start = 1'b1;
        tick();                                   // cycle 1: FETCH
        chk("c1_fetch", {ins_req, ins_addr, busy}, {1'b1, 8'h00, 1'b1});
        tick();                                   // cycle 2: EXEC LDI
        chk("c2_ldi", {alu_wen, bus_out, alu_op, alu_inc, alu_clr, ins_req},
            {1'b1, 8'h14, 3'b000, 1'b0, 1'b0, 1'b0});
        tick();                                   // cycle 3: SETTLE
        chk("c3_settle", {alu_wen, bus_out, ins_req, busy}, {1'b0, 8'h00, 1'b0, 1'b1});
        tick();                                   // cycle 4: FETCH 1
        chk("c4_fetch", {ins_req, ins_addr}, {1'b1, 8'h01});
        tick();                                   // cycle 5: EXEC INC
        chk("c5_inc", {alu_inc, alu_wen, alu_clr}, {1'b1, 1'b0, 1'b0});
        tick();
        tick();
        tick();                                   // cycle 8: EXEC HALT
        chk("c8_exec_halt", {halted, busy}, {1'b0, 1'b1});
        tick();                                   // cycle 9: HALT
        chk("c9_halted", {halted, busy, ins_addr, ins_req}, {1'b1, 1'b0, 8'h02, 1'b0});
        tick();
        tick();
        chk("halt_sticky", {halted, ins_req, alu_wen, alu_inc}, {1'b1, 1'b0, 1'b0, 1'b0});
        start = 1'b0;

        // Wait states: 4 cycles per fetch gives 7 cycles per instruction
        do_reset();
        wait_cycles = 4;
        rom[0] = 16'h0000;
        rom[1] = 16'h7000;
        pulse_start();
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("ws_fetch0_c%0d", c), {ins_req, ins_addr}, {1'b1, 8'h00});
            if (c < 5) tick();
        end
        tick();                                   // cycle 6: EXEC
        chk("ws_exec", {ins_req, busy}, {1'b0, 1'b1});
        tick();
        tick();                                   // cycle 8: next FETCH
        for (int c = 8; c <= 12; c++) begin
            chk($sformatf("ws_fetch1_c%0d", c), {ins_req, ins_addr}, {1'b1, 8'h01});
            tick();
        end
        tick();                                   // cycle 14: HALT
        chk("ws_halted", halted, 1'b1);
        wait_cycles = 0;

        // Branch taken: CLR; JZ 0x40 with alu_dout=0
        do_reset();
        rom[0] = 16'h4000;
        rom[1] = 16'h6040;
        rom[2] = 16'h7000;
        rom[8'h40] = 16'h7000;
        alu_dout = 8'h00;
        pulse_start();
        tick();                                   // cycle 2: EXEC CLR
        chk("clr_strobe", {alu_clr, alu_wen, alu_inc}, {1'b1, 1'b0, 1'b0});
        repeat (5) tick();                        // cycle 7: FETCH target
        chk("jz_taken", {ins_req, ins_addr}, {1'b1, 8'h40});

        // Branch not taken with alu_dout=0x05
        do_reset();
        alu_dout = 8'h05;
        pulse_start();
        repeat (6) tick();
        chk("jz_not_taken", {ins_req, ins_addr}, {1'b1, 8'h02});
        alu_dout = 8'h00;

        // JMP 0xFF, illegal opcode at 0xFF, pc wraps to 0
        do_reset();
        rom[0] = 16'h50FF;
        rom[8'hFF] = 16'hF000;
        pulse_start();
        tick();                                   // cycle 2: EXEC JMP
        chk("jmp_no_illegal", illegal, 1'b0);
        tick();
        tick();                                   // cycle 4
        chk("jmp_target", {ins_req, ins_addr}, {1'b1, 8'hFF});
        tick();                                   // cycle 5
        chk("illegal_pulse", {illegal, alu_wen, alu_inc, alu_clr}, {1'b1, 1'b0, 1'b0, 1'b0});
        tick();
        chk("illegal_once", illegal, 1'b0);
        tick();                                   // cycle 7
        chk("pc_wrap", {ins_req, ins_addr}, {1'b1, 8'h00});

        // Async reset in the EXEC cycle of OP 011
        do_reset();
        rom[0] = 16'h2355;
        pulse_start();
        tick();
        chk("op_exec", {alu_wen, alu_op, bus_out}, {1'b1, 3'b011, 8'h55});
        #2;
        RST = 1'b1;
        #1;
        chk("async_abort", {alu_wen, alu_op, bus_out, busy, ins_addr},
            {1'b0, 3'b000, 8'h00, 1'b0, 8'h00});
        tick();
        RST = 1'b0;
        pulse_start();
        chk("restart_addr", {ins_req, ins_addr}, {1'b1, 8'h00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
